// File: rtl/alu_mc_pkg.sv
// Shared opcode and FSM encodings for the multi-cycle ALU and its datapath.
package alu_mc_pkg;

    typedef enum logic [2:0] {
        OP_FWD  = 3'b000,
        OP_ADD  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_SUB  = 3'b100,
        OP_MULT = 3'b101,
        OP_SLL  = 3'b110,
        OP_SRA  = 3'b111
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic logic is_iterative(input op_e op);
        return (op == OP_MULT) || (op == OP_SLL) || (op == OP_SRA);
    endfunction

    function automatic logic is_shift(input op_e op);
        return (op == OP_SLL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_mc_comb.sv
// Purely combinational single-cycle datapath: FWD/ADD/AND/OR/SUB.
module alu_comb
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // Iterative opcodes never take this path; they resolve to zero so every code is defined.
    always_comb begin
        y = '0;
        case (op)
            OP_FWD:  y = b;
            OP_ADD:  y = a + b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_SUB:  y = a - b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops finish at the START edge; MULT and shifts
// iterate one step per clock under a START/BUSY/DONE handshake.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHIFT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [2:0]       select,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0]   WIDTH_V  = WIDTH'(WIDTH);
    localparam logic [SHIFT_W-1:0] CNT_FULL = SHIFT_W'(WIDTH);
    localparam logic [SHIFT_W-1:0] CNT_ONE  = SHIFT_W'(1);

    state_e             state_q,  state_d;
    op_e                op_q,     op_d;
    logic [WIDTH-1:0]   a_q,      a_d;
    logic [WIDTH-1:0]   b_q,      b_d;
    logic [WIDTH-1:0]   acc_q,    acc_d;
    logic [SHIFT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;

    op_e                op_in;
    logic [WIDTH-1:0]   comb_y;
    logic [SHIFT_W-1:0] shift_cnt;
    logic [WIDTH-1:0]   a_n;
    logic [WIDTH-1:0]   b_n;
    logic [WIDTH-1:0]   acc_n;

    assign op_in = op_e'(select);

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .op (op_in),
        .a  (data1),
        .b  (data2),
        .y  (comb_y)
    );

    // Amounts at or beyond WIDTH saturate: SLL drains to 0, SRA fills with sign.
    always_comb begin
        if (data2 >= WIDTH_V) begin
            shift_cnt = CNT_FULL;
        end else begin
            shift_cnt = data2[SHIFT_W-1:0];
        end
    end

    // One shift-add / shift step of the captured operands.
    always_comb begin
        a_n   = a_q;
        b_n   = b_q;
        acc_n = acc_q;
        case (op_q)
            OP_MULT: begin
                acc_n = b_q[0] ? (acc_q + a_q) : acc_q;
                a_n   = a_q << 1;
                b_n   = b_q >> 1;
            end
            OP_SLL:  a_n = a_q << 1;
            OP_SRA:  a_n = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
            default: a_n = a_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (!is_iterative(op_in)) begin
                        result_d = comb_y;
                        done_d   = 1'b1;
                    end else if (is_shift(op_in) && (data2 == '0)) begin
                        result_d = data1;
                        done_d   = 1'b1;
                    end else begin
                        op_d    = op_in;
                        a_d     = data1;
                        b_d     = data2;
                        acc_d   = '0;
                        cnt_d   = (op_in == OP_MULT) ? CNT_FULL : shift_cnt;
                        busy_d  = 1'b1;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                a_d   = a_n;
                b_d   = b_n;
                acc_d = acc_n;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    result_d = (op_q == OP_MULT) ? acc_n : a_n;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_FWD;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign zero   = (result_q == '0);
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: stimulus pushes expected results, a monitor
// pops and checks them on every DONE pulse.
module tb_alu_mc;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] data1;
    logic [7:0] data2;
    logic [2:0] select;
    logic [7:0] result;
    logic       zero;
    logic       busy;
    logic       done;

    typedef struct {
        string      name;
        logic [7:0] res;
        int         start_edge;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;
    int   cyc;
    int   busy_cnt;

    alu_mc #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .data1  (data1),
        .data2  (data2),
        .select (select),
        .result (result),
        .zero   (zero),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_result"}, int'(result), int'(e.res));
                    check({e.name, "_zero"}, int'(zero), int'(e.res == 8'h00));
                    check({e.name, "_latency"}, cyc - e.start_edge + 1, e.lat);
                    check({e.name, "_busy_cycles"}, busy_cnt, e.lat - 1);
                    $display("txn %s result=0x%02h latency=%0d busy=%0d", e.name, result,
                             cyc - e.start_edge + 1, busy_cnt);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] res, input int lat, input string name, input bit push);
        exp_t e;
        data1  = a;
        data2  = b;
        select = op;
        start  = 1'b1;
        if (push) begin
            e.name = name; e.res = res; e.start_edge = cyc + 1; e.lat = lat;
            sb.push_back(e);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] res, input int lat, input string name);
        @(negedge clk);
        drive(op, a, b, res, lat, name, 1'b1);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("drain_timeout", n, 0);
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; busy_cnt = 0;
        rst = 1'b1; start = 1'b0; data1 = '0; data2 = '0; select = '0;
        repeat (2) @(negedge clk);
        check("reset_result", int'(result), 8'h00);
        check("reset_zero", int'(zero), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        rst = 1'b0;

        issue(3'b001, 8'h05, 8'h03, 8'h08, 1, "add_05_03");
        issue(3'b001, 8'hFF, 8'h01, 8'h00, 1, "add_ff_01");
        issue(3'b010, 8'hF0, 8'h3C, 8'h30, 1, "and_f0_3c");
        drain();

        // MULT with a second START during BUSY that must be ignored.
        issue(3'b101, 8'h0D, 8'h0B, 8'h8F, 9, "mult_0d_0b");
        @(negedge clk);
        drive(3'b101, 8'h02, 8'h02, 8'h00, 0, "ignored", 1'b0);
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (4) @(negedge clk);
        check("mult_hold_result", int'(result), 8'h8F);

        issue(3'b101, 8'hFF, 8'hFF, 8'h01, 9, "mult_ff_ff");
        drain();
        issue(3'b111, 8'h90, 8'h03, 8'hF2, 4, "sra_90_3");
        drain();
        issue(3'b110, 8'h81, 8'h09, 8'h00, 9, "sll_81_9");
        drain();
        issue(3'b111, 8'h80, 8'h20, 8'hFF, 9, "sra_80_20");
        drain();
        issue(3'b110, 8'h5A, 8'h00, 8'h5A, 1, "sll_5a_0");
        drain();

        // Back-to-back single-cycle ops with START held high.
        @(negedge clk);
        drive(3'b100, 8'h03, 8'h05, 8'hFE, 1, "sub_03_05", 1'b1);
        @(negedge clk);
        drive(3'b000, 8'h00, 8'h7E, 8'h7E, 1, "fwd_7e", 1'b1);
        @(negedge clk);
        drive(3'b011, 8'h30, 8'h0C, 8'h3C, 1, "or_30_0c", 1'b1);
        @(negedge clk);
        start = 1'b0;
        drain();

        // Asynchronous reset in the 3rd RUN cycle of a MULT.
        @(negedge clk);
        drive(3'b101, 8'h0D, 8'h0B, 8'h00, 0, "aborted", 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_busy_before", int'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_result", int'(result), 8'h00);
        check("abort_done", int'(done), 0);
        check("abort_zero", int'(zero), 1);
        busy_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_no_done_result", int'(result), 8'h00);
        check("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
